// File: rtl/uart_rsr.sv
// UART receive shift register: start/data/stop deserialiser driven by external baud strobes.
// Define RSR_PARITY_EN to receive one even-parity bit between the data bits and the stop bit.
module uart_rsr #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 receive_line,
  input  logic                 sample_tick,
  input  logic                 bit_tick,
  input  logic                 bit_tick_one_and_half,
  input  logic                 data_read_ack,
  output logic [DATA_SIZE-1:0] d_o,
  output logic                 data_ready,
  output logic                 frame_error
);

  localparam int HALF  = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(HALF + 1);
  localparam int IDX_W = $clog2(DATA_SIZE + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] FIRST  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef RSR_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 st_q, bt_q, ht_q;
  logic                 s_ev, b_ev, h_ev;
  logic                 par_ok;

  // Ticks may be level-high for several clocks; only the rising edge counts.
  assign s_ev = sample_tick & ~st_q;
  assign b_ev = bit_tick & ~bt_q;
  assign h_ev = bit_tick_one_and_half & ~ht_q;

`ifdef RSR_PARITY_EN
  logic perr_q, perr_d;
  assign par_ok = ~perr_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
`ifdef RSR_PARITY_EN
    perr_d  = perr_q;
`endif
    // Ack clears first so that a good stop bit in the same cycle overrides it.
    if (data_read_ack) rdy_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!receive_line) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (s_ev) begin
          if (receive_line) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_d   = '0;
            ferr_d  = 1'b0;
            state_d = FIRST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIRST: begin
        if (h_ev) begin
          sh_d    = {receive_line, sh_q[DATA_SIZE-1:1]};
          idx_d   = IDX_W'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (b_ev) begin
          sh_d  = {receive_line, sh_q[DATA_SIZE-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(DATA_SIZE - 1)) begin
`ifdef RSR_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RSR_PARITY_EN
      PARITY: begin
        if (b_ev) begin
          perr_d  = ^{sh_q, receive_line};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (b_ev) begin
          if (receive_line && par_ok) begin
            dout_d = sh_q;
            rdy_d  = 1'b1;
            ferr_d = 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      st_q    <= 1'b0;
      bt_q    <= 1'b0;
      ht_q    <= 1'b0;
`ifdef RSR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      st_q    <= sample_tick;
      bt_q    <= bit_tick;
      ht_q    <= bit_tick_one_and_half;
`ifdef RSR_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign d_o         = dout_q;
  assign data_ready  = rdy_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rsr.sv
// Directed bench for uart_rsr (DATA_SIZE=7, OVERSAMPLE=16): frame table plus hand-written corner sequences.
module tb_uart_rsr;
  localparam int DW = 7;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          receive_line = 1'b1;
  logic          sample_tick = 1'b0;
  logic          bit_tick = 1'b0;
  logic          bit_tick_one_and_half = 1'b0;
  logic          data_read_ack = 1'b0;
  logic [DW-1:0] d_o;
  logic          data_ready;
  logic          frame_error;

  int n_cmp = 0;
  int n_fail = 0;

  uart_rsr #(.DATA_SIZE(DW), .OVERSAMPLE(OS)) dut (
    .clk                  (clk),
    .reset                (reset),
    .receive_line         (receive_line),
    .sample_tick          (sample_tick),
    .bit_tick             (bit_tick),
    .bit_tick_one_and_half(bit_tick_one_and_half),
    .data_read_ack        (data_read_ack),
    .d_o                  (d_o),
    .data_ready           (data_ready),
    .frame_error          (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          par_bad;
    int            hold;
    logic          spur;
    logic          ack_stop;
    logic          ack_after;
    logic [DW-1:0] exp_d;
    logic          exp_rdy;
    logic          exp_ferr;
  } vec_t;

  vec_t tbl[$];

`ifdef RSR_PARITY_EN
  localparam logic [DW-1:0] LAST_GOOD = 7'h03;
`else
  localparam logic [DW-1:0] LAST_GOOD = 7'h6E;
`endif

  function automatic vec_t mk(input logic [DW-1:0] data, input logic stop, input logic par_bad,
                              input int hold, input logic spur, input logic ack_stop,
                              input logic ack_after, input logic [DW-1:0] exp_d,
                              input logic exp_rdy, input logic exp_ferr);
    vec_t v;
    v.data = data; v.stop = stop; v.par_bad = par_bad; v.hold = hold; v.spur = spur;
    v.ack_stop = ack_stop; v.ack_after = ack_after; v.exp_d = exp_d;
    v.exp_rdy = exp_rdy; v.exp_ferr = exp_ferr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [DW-1:0] ed, input logic er, input logic ef);
    check({name, ".d_o"}, 32'(d_o), 32'(ed));
    check({name, ".data_ready"}, 32'(data_ready), 32'(er));
    check({name, ".frame_error"}, 32'(frame_error), 32'(ef));
  endtask

  // which: 0 sample_tick, 1 bit_tick, 2 bit_tick_one_and_half
  task automatic pulse(input int which, input int hold);
    @(negedge clk);
    case (which)
      0:       sample_tick = 1'b1;
      1:       bit_tick = 1'b1;
      default: bit_tick_one_and_half = 1'b1;
    endcase
    for (int k = 0; k < hold; k++) @(negedge clk);
    sample_tick = 1'b0;
    bit_tick = 1'b0;
    bit_tick_one_and_half = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    @(negedge clk);
    receive_line = 1'b0;
    @(negedge clk);
    for (int i = 0; i < OS / 2; i++) pulse(0, v.hold);
    receive_line = v.data[0];
    if (v.spur) pulse(1, 1);
    pulse(2, v.hold);
    for (int i = 1; i < DW; i++) begin
      receive_line = v.data[i];
      pulse(1, v.hold);
    end
`ifdef RSR_PARITY_EN
    receive_line = (^v.data) ^ v.par_bad;
    pulse(1, v.hold);
`endif
    receive_line = v.stop;
    @(negedge clk);
    bit_tick = 1'b1;
    data_read_ack = v.ack_stop;
    @(negedge clk);
    data_read_ack = 1'b0;
    receive_line = 1'b1;
    for (int k = 1; k < v.hold; k++) @(negedge clk);
    bit_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    data_read_ack = 1'b1;
    @(negedge clk);
    data_read_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          data  stp pbad hold spur ackS ackA  exp_d  rdy ferr
    tbl.push_back(mk(7'h55, 1, 0, 1, 0, 0, 1, 7'h55, 1, 0));
    tbl.push_back(mk(7'h3C, 0, 0, 1, 0, 0, 0, 7'h55, 0, 1));
    tbl.push_back(mk(7'h01, 1, 0, 3, 1, 0, 0, 7'h01, 1, 0));
    tbl.push_back(mk(7'h12, 1, 0, 1, 0, 0, 0, 7'h12, 1, 0));
    tbl.push_back(mk(7'h6E, 1, 0, 2, 0, 1, 1, 7'h6E, 1, 0));
`ifdef RSR_PARITY_EN
    tbl.push_back(mk(7'h03, 1, 1, 1, 0, 0, 0, 7'h6E, 0, 1));
    tbl.push_back(mk(7'h03, 1, 0, 1, 0, 0, 1, 7'h03, 1, 0));
`endif
    tbl.push_back(mk(7'h2A, 0, 0, 1, 0, 0, 0, LAST_GOOD, 0, 1));

    // Reset held low while the line and ticks wiggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      receive_line = i[0];
      sample_tick = ~i[0];
      bit_tick = i[1];
      check_out("reset_hold", '0, 1'b0, 1'b0);
    end
    @(negedge clk);
    receive_line = 1'b1;
    sample_tick = 1'b0;
    bit_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_out("after_reset", '0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      send_frame(tbl[i]);
      check_out($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_rdy, tbl[i].exp_ferr);
      if (tbl[i].ack_after) begin
        ack_pulse();
        @(negedge clk);
        check_out($sformatf("vec%0d_ack", i), tbl[i].exp_d, 1'b0, tbl[i].exp_ferr);
      end
    end

    // Start-bit glitch: 3 low samples then line high, flags must not move
    @(negedge clk);
    receive_line = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(0, 1);
    receive_line = 1'b1;
    pulse(0, 1);
    check_out("glitch", LAST_GOOD, 1'b0, 1'b1);

    ack_pulse();
    @(negedge clk);
    check_out("ack_idle", LAST_GOOD, 1'b0, 1'b1);

    send_frame(mk(7'h7F, 1, 0, 1, 0, 0, 0, 7'h7F, 1, 0));
    check_out("after_glitch", 7'h7F, 1'b1, 1'b0);

    // Reset in the middle of a frame
    @(negedge clk);
    receive_line = 1'b0;
    @(negedge clk);
    for (int i = 0; i < OS / 2; i++) pulse(0, 1);
    receive_line = 1'b1;
    pulse(2, 1);
    receive_line = 1'b0;
    pulse(1, 1);
    reset = 1'b0;
    #1;
    check_out("midframe_reset", '0, 1'b0, 1'b0);
    @(negedge clk);
    receive_line = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(mk(7'h4B, 1, 0, 1, 0, 0, 0, 7'h4B, 1, 0));
    check_out("post_reset", 7'h4B, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
